// File: rtl/latch_mon_pkg.sv
// Shared definitions for the latch Q monitor: FSM state encoding and the
// default parameter values used by the top and the synchronizer.
package latch_mon_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } mon_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_WIDTH       = 8;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer bringing an asynchronous level into the Clk domain.
module sync_bit
    import latch_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic Clk,
    input  logic Rst,
    input  logic D_in,
    output logic S_out
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_in};
        end
    end

    assign S_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/latch_q_monitor.sv
// Synchronizes and debounces a latch Q output, pulses on committed edges,
// counts transitions and queues a single-entry event record with overflow.
module latch_q_monitor
    import latch_mon_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Q_in,
    output logic                 Q_stable,
    output logic                 Rise,
    output logic                 Fall,
    output logic                 Evt_valid,
    input  logic                 Evt_ready,
    output logic                 Evt_dir,
    output logic [CNT_WIDTH-1:0] Evt_count,
    output logic                 Overflow,
    input  logic                 Clr_ovf,
    output mon_state_e           Dbg_state
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic                 s;
    mon_state_e           state_q;
    logic [DBW-1:0]       dbc_q;
    logic                 q_stable_q;
    logic                 rise_q;
    logic                 fall_q;
    logic                 evt_valid_q;
    logic                 evt_dir_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] evt_count_q;

    logic dbc_last;
    logic commit_rise;
    logic commit_fall;
    logic commit;
    logic accept;
    logic drop;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .Clk  (Clk),
        .Rst  (Rst),
        .D_in (Q_in),
        .S_out(s)
    );

    // The sample that moves IDLE_x into CHK_x is the first stable sample, so the
    // counter only tracks the matches that follow it.
    assign dbc_last    = (int'(dbc_q) == DEBOUNCE_CYCLES - 2);
    assign commit_rise = s && ((state_q == CHK_HIGH && dbc_last) ||
                               (state_q == IDLE_LOW && DEBOUNCE_CYCLES == 1));
    assign commit_fall = !s && ((state_q == CHK_LOW && dbc_last) ||
                                (state_q == IDLE_HIGH && DEBOUNCE_CYCLES == 1));
    assign commit      = commit_rise || commit_fall;

    // Evt_valid/Evt_dir hold until a cycle with Evt_valid && Evt_ready; that
    // same cycle frees the slot so a coincident commit is loaded, not dropped.
    assign accept      = !evt_valid_q || Evt_ready;
    assign drop        = commit && !accept;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE_LOW;
            dbc_q       <= '0;
            q_stable_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_dir_q   <= 1'b0;
            ovf_q       <= 1'b0;
            evt_count_q <= '0;
        end else begin
            rise_q <= commit_rise;
            fall_q <= commit_fall;

            unique case (state_q)
                IDLE_LOW: begin
                    if (commit_rise) begin
                        state_q    <= IDLE_HIGH;
                        q_stable_q <= 1'b1;
                    end else if (s) begin
                        state_q <= CHK_HIGH;
                        dbc_q   <= '0;
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state_q <= IDLE_LOW;
                    end else if (commit_rise) begin
                        state_q    <= IDLE_HIGH;
                        q_stable_q <= 1'b1;
                    end else begin
                        dbc_q <= dbc_q + DBW'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (commit_fall) begin
                        state_q    <= IDLE_LOW;
                        q_stable_q <= 1'b0;
                    end else if (!s) begin
                        state_q <= CHK_LOW;
                        dbc_q   <= '0;
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state_q <= IDLE_HIGH;
                    end else if (commit_fall) begin
                        state_q    <= IDLE_LOW;
                        q_stable_q <= 1'b0;
                    end else begin
                        dbc_q <= dbc_q + DBW'(1);
                    end
                end
                default: state_q <= IDLE_LOW;
            endcase

            if (commit && !(&evt_count_q)) begin
                evt_count_q <= evt_count_q + CNT_WIDTH'(1);
            end

            if (commit && accept) begin
                evt_valid_q <= 1'b1;
                evt_dir_q   <= commit_rise;
            end else if (evt_valid_q && Evt_ready) begin
                evt_valid_q <= 1'b0;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (Clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign Q_stable  = q_stable_q;
    assign Rise      = rise_q;
    assign Fall      = fall_q;
    assign Evt_valid = evt_valid_q;
    assign Evt_dir   = evt_dir_q;
    assign Evt_count = evt_count_q;
    assign Overflow  = ovf_q;
    assign Dbg_state = state_q;

endmodule

// File: tb/tb_latch_q_monitor.sv
// Self-checking bench for latch_q_monitor: phase table, pulse scoreboard,
// and hand-written overflow / reset-abort sequences.
module tb_latch_q_monitor;
    import latch_mon_pkg::*;

    localparam int LAT = 2 + 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Q_in;
    logic       Evt_ready;
    logic       Clr_ovf;
    logic       Q_stable, Rise, Fall, Evt_valid, Evt_dir, Overflow;
    logic [7:0] Evt_count;
    mon_state_e Dbg_state;

    logic       c2_qs, c2_rise, c2_fall, c2_valid, c2_dir, c2_ovf;
    logic [1:0] c2_count;
    mon_state_e c2_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic model_lvl;
    int model_cnt;
    logic rise_prev = 1'b0;
    logic fall_prev = 1'b0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic lvl;
        int   hold;
        logic rdy;
        logic e_qs;
        int   e_cnt;
        logic e_val;
        logic e_dir;
        logic e_ovf;
    } vec_t;

    vec_t vecs[7];

    latch_q_monitor dut (
        .Clk(Clk), .Rst(Rst), .Q_in(Q_in), .Q_stable(Q_stable), .Rise(Rise),
        .Fall(Fall), .Evt_valid(Evt_valid), .Evt_ready(Evt_ready),
        .Evt_dir(Evt_dir), .Evt_count(Evt_count), .Overflow(Overflow),
        .Clr_ovf(Clr_ovf), .Dbg_state(Dbg_state)
    );

    latch_q_monitor #(.CNT_WIDTH(2)) dut_c2 (
        .Clk(Clk), .Rst(Rst), .Q_in(Q_in), .Q_stable(c2_qs), .Rise(c2_rise),
        .Fall(c2_fall), .Evt_valid(c2_valid), .Evt_ready(Evt_ready),
        .Evt_dir(c2_dir), .Evt_count(c2_count), .Overflow(c2_ovf),
        .Clr_ovf(Clr_ovf), .Dbg_state(c2_state)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string tag, input logic qs, input int cnt,
                                 input logic val, input logic dir, input logic ovf);
        int cnt2;
        cnt2 = (cnt > 3) ? 3 : cnt;
        check({tag, "_qs"},    Q_stable,  qs);
        check({tag, "_cnt"},   Evt_count, cnt);
        check({tag, "_cnt2"},  c2_count,  cnt2);
        check({tag, "_valid"}, Evt_valid, val);
        check({tag, "_dir"},   Evt_dir,   dir);
        check({tag, "_ovf"},   Overflow,  ovf);
    endtask

    task automatic check_reset_state(input string tag);
        check_outputs(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check({tag, "_rise"},  Rise, 0);
        check({tag, "_fall"},  Fall, 0);
        check({tag, "_state"}, Dbg_state, IDLE_LOW);
    endtask

    // Drive a new level at a negedge; a level change that will be held long
    // enough to commit is pushed to the scoreboard with its commit cycle.
    task automatic drive_level(input logic lvl, input logic rdy, input bit commits);
        Q_in      = lvl;
        Evt_ready = rdy;
        if (commits && lvl != model_lvl) begin
            exp_q.push_back({lvl, 32'(cyc + LAT)});
            model_lvl = lvl;
            model_cnt++;
        end
    endtask

    task automatic do_reset(input int n);
        Rst       = 1'b1;
        Q_in      = 1'b0;
        Evt_ready = 1'b0;
        Clr_ovf   = 1'b0;
        repeat (n) @(negedge Clk);
        model_lvl = 1'b0;
        model_cnt = 0;
    endtask

    always @(negedge Clk) begin
        if (Rise || Fall) begin
            logic [32:0] e;
            check("rise_fall_excl", 32'(Rise & Fall), 0);
            check("pulse_width", 32'(rise_prev | fall_prev), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rise=%0d fall=%0d at cycle %0d, none expected",
                         Rise, Fall, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_dir", 32'(Rise), 32'(e[32]));
                check("pulse_cycle", cyc, e[31:0]);
                check("pulse_qs", 32'(Q_stable), 32'(e[32]));
                check("pulse_valid", 32'(Evt_valid), 1);
            end
        end
        rise_prev <= Rise;
        fall_prev <= Fall;
    end

    initial begin
        vecs[0] = '{1'b1, 10, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0,  2, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 10, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 10, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 10, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 10, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 10, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b1};

        do_reset(2);
        check_reset_state("reset");
        Rst = 1'b0;
        repeat (3) @(negedge Clk);

        for (int i = 0; i < 7; i++) begin
            drive_level(vecs[i].lvl, vecs[i].rdy, vecs[i].hold >= LAT);
            repeat (vecs[i].hold) @(negedge Clk);
            check_outputs($sformatf("v%0d", i), vecs[i].e_qs, vecs[i].e_cnt,
                          vecs[i].e_val, vecs[i].e_dir, vecs[i].e_ovf);
            check($sformatf("v%0d_model_cnt", i), Evt_count, model_cnt);
        end

        Clr_ovf = 1'b1;
        @(negedge Clk);
        Clr_ovf = 1'b0;
        check("clr_ovf", Overflow, 0);

        drive_level(1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge Clk);
        check_outputs("fall_pend", 1'b0, 6, 1'b1, 1'b0, 1'b0);

        // Drop coincides with Clr_ovf: the set must win.
        drive_level(1'b1, 1'b0, 1'b1);
        repeat (LAT - 1) @(negedge Clk);
        Clr_ovf = 1'b1;
        @(negedge Clk);
        Clr_ovf = 1'b0;
        check_outputs("set_wins", 1'b1, 7, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge Clk);
        Clr_ovf = 1'b1;
        @(negedge Clk);
        Clr_ovf = 1'b0;
        check("clr_after_set", Overflow, 0);
        check("pend_held_dir", Evt_dir, 0);

        // Reset two cycles after S first shows 1 aborts the pending check.
        do_reset(2);
        check_reset_state("reset2");
        Rst = 1'b0;
        repeat (4) @(negedge Clk);
        Q_in = 1'b1;
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check_reset_state("abort");
        repeat (8) @(negedge Clk);
        check_reset_state("abort_hold");
        Q_in = 1'b0;
        Rst  = 1'b0;
        repeat (8) @(negedge Clk);
        check_reset_state("abort_after");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/latch_q_monitor.md
LATCH_Q_MONITOR -- requirements
Module: latch_q_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth, >=2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to commit a level, >=1.
REQ-003 Parameter CNT_WIDTH, default 8: width of the transition counter.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Q_in  input  1  latch output Q, asynchronous to Clk.
REQ-007 Q_stable  output  1  debounced, synchronized level of Q_in.
REQ-008 Rise  output  1  one-cycle pulse on committed 0->1 transition.
REQ-009 Fall  output  1  one-cycle pulse on committed 1->0 transition.
REQ-010 Evt_valid  output  1  event record pending.
REQ-011 Evt_ready  input  1  consumer accepts event when high with Evt_valid.
REQ-012 Evt_dir  output  1  direction of pending event; 1 = rise, 0 = fall.
REQ-013 Evt_count  output  CNT_WIDTH  committed transitions since reset, saturating.
REQ-014 Overflow  output  1  sticky: an event was dropped.
REQ-015 Clr_ovf  input  1  clears Overflow.

Function
REQ-016 Q_in SHALL pass through a SYNC_STAGES-deep flop chain before any other use; the chain output is the synchronized sample S.
REQ-017 FSM states SHALL be IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW.
REQ-018 Transitions:
- IDLE_LOW with S=1 -> CHK_HIGH, debounce counter cleared.
- IDLE_HIGH with S=0 -> CHK_LOW, debounce counter cleared.
REQ-019 In CHK_x, each cycle S matches the candidate level SHALL increment the debounce counter; on the DEBOUNCE_CYCLES-th match the block SHALL commit: go to IDLE_x, update Q_stable, pulse Rise/Fall.
REQ-020 In CHK_x, any S mismatch SHALL return the FSM to the prior IDLE state. No pulse, no count change, Q_stable unchanged.
REQ-021 Latency: with Q_in held steady, Q_stable and the pulse SHALL assert exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new Q_in level (6 at defaults).
REQ-022 Rise and Fall SHALL never be high together and SHALL each last exactly one cycle.
REQ-023 On commit, Evt_count SHALL increment by 1, holding at all-ones once saturated.
REQ-024 On commit with Evt_valid=0, or with Evt_valid=1 and Evt_ready=1 in the same cycle, the block SHALL load the new event: Evt_valid=1, Evt_dir=direction.
REQ-025 On commit with Evt_valid=1 and Evt_ready=0, the new event SHALL be dropped, Overflow set to 1, and the pending event held unchanged.
REQ-026 Evt_valid and Evt_dir SHALL remain stable until the handshake; after handshake with no commit, Evt_valid=0 next cycle.
REQ-027 Overflow SHALL clear on Clr_ovf=1; if set and clear coincide, set SHALL win.

Reset
REQ-028 Rst=1 at a rising edge SHALL force, next cycle:
- synchronizer flops and debounce counter = 0
- FSM = IDLE_LOW
- Q_stable, Rise, Fall, Evt_valid, Evt_dir, Overflow = 0
- Evt_count = 0
REQ-029 Reset during CHK_HIGH/CHK_LOW SHALL abort the check with no pulse; reset SHALL take priority over all other inputs.

Structure
REQ-030 A shared package latch_mon_pkg SHALL hold the FSM state enumeration and the parameter defaults.
REQ-031 The synchronizer SHALL be a separate sub-module sync_bit, parameterized by SYNC_STAGES, with the same Clk/Rst.
REQ-032 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification
REQ-033 Rst high 2 cycles, Q_in=0 -> all outputs 0; FSM IDLE_LOW.
REQ-034 Q_in 0->1 held 10 cycles, Evt_ready=1 -> at edge 6:
- Q_stable=1
- Rise high 1 cycle
- Evt_valid=1, Evt_dir=1
- Evt_count=1
REQ-035 Q_in high for 2 cycles then low -> Rise never asserts, Q_stable=0, Evt_count=0.
REQ-036 Evt_ready=0, Q_in 0->1->0, each held 10 cycles:
- Evt_dir stays 1
- Overflow=1
- Evt_count=2
- then Clr_ovf 1 cycle -> Overflow=0
REQ-037 CNT_WIDTH=2, 5 committed transitions -> Evt_count=3.
REQ-038 Rst asserted 2 cycles after S first shows 1 -> next cycle all outputs 0, no Rise at any later cycle while Rst is held.
